// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads the register file and resolves RAW hazards. MEM
// and WB results are bypassed into the operands. The stage interlocks when a
// producer sits in ID/EX, or when a load in MEM has no data yet. The resolved
// operands are registered into the ID/EX pipeline register, and a saturating
// counter tracks hazard stall cycles.
module operand_fetch_stage #(
    parameter int XLEN = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_reg_write,
    input  logic            id_is_load,
    input  logic            flush,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            mem_valid,
    input  logic            mem_reg_write,
    input  logic            mem_is_load,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_is_load,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [CNTW-1:0] stall_count
);

    // Handshake: the ID instruction moves into ID/EX on a rising edge where
    // id_valid && id_ready && !flush. While id_ready is low, the upstream stage
    // holds every id_* field stable. A flush consumes the ID instruction
    // (id_ready is high) without transferring it.

    logic            memCanForward;
    logic            memLoadBusy;
    logic            exWillWrite;
    logic            pendingRs1;
    logic            pendingRs2;
    logic            stall;
    logic            accept;
    logic [XLEN-1:0] op1Resolved;
    logic [XLEN-1:0] op2Resolved;

    // The priority order is x0, then MEM, then WB, then the array. x0 is
    // forced to zero because the array contents for x0 are not trusted.
    function automatic logic [XLEN-1:0] resolveSrc(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rfData,
        input logic            memFwd,
        input logic [4:0]      memRd,
        input logic [XLEN-1:0] memData,
        input logic            wbFwd,
        input logic [4:0]      wbRd,
        input logic [XLEN-1:0] wbData
    );
        if (src == 5'd0) begin
            return '0;
        end else if (memFwd && (memRd == src)) begin
            return memData;
        end else if (wbFwd && (wbRd == src)) begin
            return wbData;
        end
        return rfData;
    endfunction

    // A source is pending when its value is not yet available anywhere.
    // This is the case when the producer is still in ID/EX, or when the
    // producer is a load sitting in MEM.
    function automatic logic isPending(
        input logic [4:0] src,
        input logic       used,
        input logic       exW,
        input logic [4:0] exRd,
        input logic       memLd,
        input logic [4:0] memRd
    );
        return used && (src != 5'd0) &&
               ((exW && (exRd == src)) || (memLd && (memRd == src)));
    endfunction

    // Combinational read addresses, bypass selection and interlock decision.
    always_comb begin
        rf_rs1        = id_rs1;
        rf_rs2        = id_rs2;
        memCanForward = mem_valid && mem_reg_write && !mem_is_load;
        memLoadBusy   = mem_valid && mem_reg_write && mem_is_load;
        exWillWrite   = ex_valid && ex_reg_write;
        op1Resolved   = resolveSrc(id_rs1, rf_rdata1, memCanForward, mem_rd, mem_data,
                                   wb_reg_write, wb_rd, wb_data);
        op2Resolved   = resolveSrc(id_rs2, rf_rdata2, memCanForward, mem_rd, mem_data,
                                   wb_reg_write, wb_rd, wb_data);
        pendingRs1    = isPending(id_rs1, id_use_rs1, exWillWrite, ex_rd, memLoadBusy, mem_rd);
        pendingRs2    = isPending(id_rs2, id_use_rs2, exWillWrite, ex_rd, memLoadBusy, mem_rd);
        stall         = id_valid && (pendingRs1 || pendingRs2) && !flush;
        id_ready      = !stall;
        accept        = id_valid && !stall && !flush;
    end

    // ID/EX register: flush and stall both leave a bubble. Only an accepted
    // instruction updates the payload fields, so a bubble holds the old ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_rd        <= 5'd0;
            ex_op1       <= '0;
            ex_op2       <= '0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write;
            ex_is_load   <= id_is_load;
            ex_rd        <= id_rd;
            ex_op1       <= op1Resolved;
            ex_op2       <= op2Resolved;
        end else begin
            ex_valid     <= 1'b0;
        end
    end

    // Hazard stall counter. A flushed cycle is not a stall, so it is not
    // counted. The counter sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
